// File: rtl/arb_mux.sv
// arb_mux: NCH-input arbiter feeding a single registered output slot.
// Arbitration is round-robin (RR=1) or fixed lowest-index priority (RR=0).
// The output slot reloads whenever it is empty or being drained, so a
// continuously ready sink sees one word per cycle.
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int RR    = 1,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  // Modular add used by the round-robin search; base is always < NCH.
  function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NCH) begin
      s = s - NCH;
    end else begin
      s = s;
    end
    return SELW'(s);
  endfunction

  // Pointer successor; wraps explicitly so non-power-of-two NCH never
  // leaves an unused index in the pointer.
  function automatic logic [SELW-1:0] next_ptr(input logic [SELW-1:0] g);
    logic [SELW-1:0] n;
    if (g == SELW'(NCH - 1)) begin
      n = '0;
    end else begin
      n = g + SELW'(1);
    end
    return n;
  endfunction

  logic [SELW-1:0]  ptr_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SELW-1:0]  out_sel_r;

  logic [SELW-1:0]  start_s;
  logic [SELW-1:0]  idx_s;
  logic [SELW-1:0]  grant_s;
  logic             grant_vld_s;
  logic             load_en_s;

  // The slot can accept a new word when empty or when its word leaves now.
  assign load_en_s = ~out_valid_r | out_ready;

  // Fixed priority is just a round-robin search that always starts at 0.
  assign start_s = (RR != 0) ? ptr_r : '0;

  // Search for the first valid channel starting at start_s, wrapping.
  // Only in_valid feeds this path, so in_ready never depends on in_data.
  always_comb begin
    grant_s     = '0;
    grant_vld_s = 1'b0;
    idx_s       = '0;
    for (int k = 0; k < NCH; k++) begin
      idx_s = wrap_add(start_s, k);
      if (!grant_vld_s && in_valid[idx_s]) begin
        grant_vld_s = 1'b1;
        grant_s     = idx_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Ready is issued only to the granted channel, and only when the slot
  // can take the word; held low throughout reset.
  always_comb begin
    in_ready = '0;
    if (!rst && load_en_s && grant_vld_s) begin
      in_ready[grant_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Output slot and round-robin pointer; data/sel hold when the slot drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= '0;
      ptr_r       <= '0;
    end else if (load_en_s) begin
      out_valid_r <= grant_vld_s;
      if (grant_vld_s) begin
        out_data_r <= in_data[int'(grant_s)*WIDTH +: WIDTH];
        out_sel_r  <= grant_s;
        ptr_r      <= next_ptr(grant_s);
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed vectors for several arb_mux configurations plus a
// random-traffic scoreboard on a 5-channel round-robin instance.
module tb_arb_mux;

  logic clk;
  logic rst;

  // RR=1, NCH=4, WIDTH=8
  logic [3:0]  iv4;  logic [31:0] id4;  logic [3:0] ir4;
  logic        ov4;  logic [7:0]  od4;  logic [1:0] os4;  logic or4;
  // RR=0, NCH=4, WIDTH=8
  logic [3:0]  iv0;  logic [31:0] id0;  logic [3:0] ir0;
  logic        ov0;  logic [7:0]  od0;  logic [1:0] os0;  logic or0;
  // RR=1, NCH=3, WIDTH=8
  logic [2:0]  iv3;  logic [23:0] id3;  logic [2:0] ir3;
  logic        ov3;  logic [7:0]  od3;  logic [1:0] os3;  logic or3;
  // RR=1, NCH=5, WIDTH=16
  logic [4:0]  iv5;  logic [79:0] id5;  logic [4:0] ir5;
  logic        ov5;  logic [15:0] od5;  logic [2:0] os5;  logic or5;

  arb_mux #(.WIDTH(8), .NCH(4), .RR(1)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_data(id4), .in_ready(ir4),
    .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(or4));
  arb_mux #(.WIDTH(8), .NCH(4), .RR(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_data(id0), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(or0));
  arb_mux #(.WIDTH(8), .NCH(3), .RR(1)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_data(id3), .in_ready(ir3),
    .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(or3));
  arb_mux #(.WIDTH(16), .NCH(5), .RR(1)) dut5 (
    .clk(clk), .rst(rst), .in_valid(iv5), .in_data(id5), .in_ready(ir5),
    .out_valid(ov5), .out_data(od5), .out_sel(os5), .out_ready(or5));

  int n_chk;
  int n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_all();
    rst = 1'b1;
    iv4 = '0; iv0 = '0; iv3 = '0; iv5 = '0;
    or4 = 1'b0; or0 = 1'b0; or3 = 1'b0; or5 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] ir;
    logic       ov;
    logic [1:0] sel;
    logic [7:0] data;
  } vec_t;

  vec_t tbl[13];

  // scoreboard state
  logic [18:0] q[$];
  logic [18:0] e;
  logic [4:0]  x;
  int          seq[5];
  int          exp_seq[5];
  int          wait_cnt[5];
  int          g;
  int          tot_in;
  int          tot_out;
  int          ch;

  initial begin
    n_chk = 0; n_fail = 0;
    id4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    id0 = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    id3 = {8'hC2, 8'hC1, 8'hC0};
    id5 = '0;

    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA0};
    tbl[6]  = '{4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 8'hA3};
    tbl[7]  = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd3, 8'hA3};
    tbl[8]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[9]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[10] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[11] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA0};

    // reset state, with valids asserted to show in_ready is forced low
    rst = 1'b1;
    iv4 = 4'b1111; or4 = 1'b1;
    iv0 = '0; iv3 = '0; iv5 = '0; or0 = 1'b0; or3 = 1'b0; or5 = 1'b0;
    #1;
    chk("rst_in_ready", 32'(ir4), 32'h0);
    chk("rst_out_valid", 32'(ov4), 32'h0);
    chk("rst_out_data", 32'(od4), 32'h0);
    chk("rst_out_sel", 32'(os4), 32'h0);
    reset_all();

    // table: round-robin rotation, drain, empty-slot load, stall, wrap
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      iv4 = tbl[i].iv;
      or4 = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 32'(ir4), 32'(tbl[i].ir));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_out_valid", i), 32'(ov4), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_out_sel", i), 32'(os4), 32'(tbl[i].sel));
      chk($sformatf("tbl%0d_out_data", i), 32'(od4), 32'(tbl[i].data));
    end

    // fixed priority: channel 3 never wins against channel 1
    reset_all();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv0 = 4'b1010; or0 = 1'b1;
      #1;
      chk("fp_in_ready", 32'(ir0), 32'h2);
      @(posedge clk);
      #1;
      chk("fp_out_sel", 32'(os0), 32'h1);
      chk("fp_out_data", 32'(od0), 32'hB1);
    end
    iv0 = '0;

    // NCH=3 pointer wrap after granting channel 2
    reset_all();
    @(negedge clk);
    iv3 = 3'b100; or3 = 1'b1;
    #1;
    chk("n3_in_ready_a", 32'(ir3), 32'h4);
    @(posedge clk); #1;
    chk("n3_out_sel_a", 32'(os3), 32'h2);
    @(negedge clk);
    iv3 = 3'b111;
    #1;
    chk("n3_in_ready_b", 32'(ir3), 32'h1);
    @(posedge clk); #1;
    chk("n3_out_sel_b", 32'(os3), 32'h0);
    chk("n3_out_data_b", 32'(od3), 32'hC0);
    @(negedge clk); #1;
    chk("n3_in_ready_c", 32'(ir3), 32'h2);
    iv3 = '0;

    // stall holding 0x55 from channel 2, then no-bubble reload
    reset_all();
    @(negedge clk);
    id4 = {8'hA3, 8'h55, 8'hA1, 8'hA0};
    iv4 = 4'b0100; or4 = 1'b0;
    #1;
    chk("st_in_ready_load", 32'(ir4), 32'h4);
    @(posedge clk); #1;
    chk("st_loaded_data", 32'(od4), 32'h55);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iv4 = 4'b0001; or4 = 1'b0;
      #1;
      chk("st_in_ready", 32'(ir4), 32'h0);
      @(posedge clk); #1;
      chk("st_out_valid", 32'(ov4), 32'h1);
      chk("st_out_data", 32'(od4), 32'h55);
      chk("st_out_sel", 32'(os4), 32'h2);
    end
    @(negedge clk);
    or4 = 1'b1;
    #1;
    chk("st_release_ready", 32'(ir4), 32'h1);
    @(posedge clk); #1;
    chk("st_release_valid", 32'(ov4), 32'h1);
    chk("st_release_sel", 32'(os4), 32'h0);
    chk("st_release_data", 32'(od4), 32'hA0);

    // reset asserted between edges during a stall
    @(negedge clk);
    iv4 = 4'b1111; or4 = 1'b0;
    #1;
    chk("rs_stall_ready", 32'(ir4), 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_out_valid", 32'(ov4), 32'h0);
    chk("rs_out_data", 32'(od4), 32'h0);
    chk("rs_out_sel", 32'(os4), 32'h0);
    chk("rs_in_ready", 32'(ir4), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    iv4 = 4'b1111; or4 = 1'b1;
    #1;
    chk("rs_first_grant", 32'(ir4), 32'h1);
    @(posedge clk); #1;
    chk("rs_first_sel", 32'(os4), 32'h0);
    chk("rs_first_data", 32'(od4), 32'hA0);
    iv4 = '0;

    // random scoreboard on NCH=5
    reset_all();
    for (int c = 0; c < 5; c++) begin
      seq[c] = 0; exp_seq[c] = 0; wait_cnt[c] = 0;
    end
    tot_in = 0; tot_out = 0; x = '0;
    for (int cyc = 0; cyc < 10020; cyc++) begin
      @(negedge clk);
      iv5 = iv5 & ~x;
      if (cyc < 10000) begin
        for (int c = 0; c < 5; c++) begin
          if (!iv5[c] && ($urandom_range(0, 2) == 0)) begin
            iv5[c] = 1'b1;
            id5[c*16 +: 16] = {4'(c), 12'(seq[c])};
            seq[c]++;
          end
        end
        or5 = ($urandom_range(0, 3) != 0);
      end else begin
        or5 = 1'b1;
      end
      #1;
      if (ov5 && or5) begin
        tot_out++;
        if (q.size() == 0) begin
          chk("sb_unexpected_out", 32'(q.size()), 32'h1);
        end else begin
          e = q.pop_front();
          chk("sb_data", 32'(od5), 32'(e[15:0]));
          chk("sb_sel", 32'(os5), 32'(e[18:16]));
        end
        ch = int'(od5[15:12]);
        if (ch < 5) begin
          chk("sb_order", 32'(od5[11:0]), 32'(12'(exp_seq[ch])));
          exp_seq[ch]++;
        end else begin
          chk("sb_chan_tag", 32'(ch), 32'h0);
        end
      end
      if (ov5 && !or5) begin
        chk("sb_stall_ready", 32'(ir5), 32'h0);
      end
      x = iv5 & ir5;
      chk("sb_grant_issued", 32'(x != 5'b0), 32'((iv5 != 5'b0) && (!ov5 || or5)));
      if (x != 5'b0) begin
        chk("sb_onehot", 32'($countones(x)), 32'h1);
        g = 0;
        for (int c = 0; c < 5; c++) begin
          if (x[c]) g = c;
        end
        q.push_back({3'(g), id5[g*16 +: 16]});
        tot_in++;
        for (int c = 0; c < 5; c++) begin
          if (c == g) begin
            wait_cnt[c] = 0;
          end else if (iv5[c]) begin
            wait_cnt[c]++;
            chk("sb_fair", 32'(wait_cnt[c] < 5), 32'h1);
          end
        end
      end
    end
    chk("sb_queue_empty", 32'(q.size()), 32'h0);
    chk("sb_in_out_count", 32'(tot_out), 32'(tot_in));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
- REQ-001: Parameter WIDTH, default 32, is the data width of each channel in bits.
- REQ-002: Parameter NCH, default 4, is the input channel count; legal range 2..16.
- REQ-003: Parameter RR, default 1: 1 selects round-robin arbitration, 0 selects fixed priority (lowest index wins).
- REQ-004: Derived localparam SELW = $clog2(NCH).
- REQ-005: clk  input  1  sole clock; all state updates on the rising edge.
- REQ-006: rst  input  1  reset, asynchronous and active-high.
- REQ-007: in_valid  input  NCH  per-channel valid; bit i belongs to channel i.
- REQ-008: in_data  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- REQ-009: in_ready  output  NCH  per-channel ready; one-hot or zero.
- REQ-010: out_valid  output  1  output register holds a word.
- REQ-011: out_data  output  WIDTH  registered selected data.
- REQ-012: out_sel  output  SELW  index of the channel that supplied out_data.
- REQ-013: out_ready  input  1  downstream accepts the word when out_valid is also 1.

Function
- REQ-014: An input transfer on channel i SHALL occur in a cycle where in_valid[i] and in_ready[i] are both 1.
- REQ-015: An output transfer SHALL occur in a cycle where out_valid and out_ready are both 1.
- REQ-016: load_en SHALL equal (!out_valid | out_ready).
- REQ-017: in_ready[g] SHALL be 1 only when load_en=1, in_valid[g]=1 and g is the granted channel; all other in_ready bits SHALL be 0.
- REQ-018: in_ready SHALL NOT depend combinationally on in_data.
- REQ-019: With RR=0, the grant SHALL go to the lowest-index channel with in_valid set.
- REQ-020: With RR=1, the grant SHALL go to the first channel with in_valid set, searching from ptr upward and wrapping from NCH-1 to 0.
- REQ-021: ptr is a SELW-bit register; on each input transfer from channel g it SHALL update to (g+1) mod NCH, wrapping to 0 when NCH is not a power of two.
- REQ-022: ptr SHALL hold its value in cycles with no input transfer.
- REQ-023: On an input transfer from channel g, the next edge SHALL load out_data=in_data[g], out_sel=g, out_valid=1.
- REQ-024: Latency from input transfer to out_valid SHALL be exactly 1 cycle.
- REQ-025: The block SHALL sustain one transfer per cycle while out_ready=1 (simultaneous output and input transfer in the same cycle).
- REQ-026: When out_valid=1 and out_ready=0 (stall), out_data and out_sel SHALL hold, and in_ready SHALL be all zero.
- REQ-027: On an output transfer with no input transfer in the same cycle, out_valid SHALL go to 0 at the next edge; out_data and out_sel SHALL hold their last values.
- REQ-028: When no in_valid bit is set, no grant SHALL be issued and in_ready SHALL be 0.
- REQ-029: Words SHALL never be duplicated or dropped; each input transfer yields exactly one output transfer.

Reset
- REQ-030: While rst=1, out_valid, out_data, out_sel and ptr SHALL be 0, asynchronously, regardless of clk.
- REQ-031: While rst=1, in_ready SHALL be 0.
- REQ-032: A reset asserted mid-stall SHALL discard the held word; after release the first grant SHALL start the search from channel 0.

Verification
- REQ-033: Reset: assert rst between edges with out_valid=1 -> out_valid=0 and out_data=0 immediately; in_ready=0.
- REQ-034: RR=1, NCH=4, all in_valid=1, out_ready=1 held, data = 0xA0..0xA3 -> out_sel sequence 0,1,2,3,0 on consecutive cycles; out_data 0xA0,0xA1,0xA2,0xA3,0xA0.
- REQ-035: RR=0, in_valid=4'b1010 held, out_ready=1 -> every grant goes to channel 1; channel 3 is never granted.
- REQ-036: Stall: load channel 2 with 0x55, hold out_ready=0 for 3 cycles -> out_data=0x55 and out_sel=2 stable, in_ready=0; on out_ready=1 the next valid word loads on the same edge with no bubble.
- REQ-037: NCH=3, RR=1: grant channel 2 -> ptr wraps to 0; with in_valid=3'b111 the next grant is channel 0.
- REQ-038: Scoreboard with random valid/ready, 10k cycles, NCH=5 -> per-channel output order matches input order; no loss or duplication; RR=1 gives each continuously-valid channel a grant within NCH consecutive input transfers.
